seq101_share_arb: RTL
=====================

# seq101_share_arb

Round-robin scheduler that shares one serial "101" sequence-detector engine among NREQ requesters. The block accepts a WIDTH-bit word from the granted requester and shifts it MSB-first through the detector, one bit per clock. The detector is the A/B/C/D Moore machine, and its output is high in state D. The block counts detections, including overlapping ones, and returns the count tagged with the requester id. It sits between the per-channel framers and the status/interrupt logic.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: bits per word (2..16).
- IDW, $clog2(NREQ): requester id width.
- CNTW, $clog2(WIDTH+1): match counter width.

- clk  in  1  single clock, rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held high until granted.
- data  in  NREQ*WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot accept strobe; high for exactly one cycle.
- busy  out  1  high while a word is being processed (state != IDLE).
- done  out  1  one-cycle result strobe.
- done_id  out  IDW  requester id of the completed word; held until the next done.
- match_cnt  out  CNTW  number of detections in the word; held until the next done.
- match_any  out  1  match_cnt != 0; held until the next done.

## Operation
- Controller states:
  - IDLE: if any req bit is high, select the winner round-robin, starting from the index after last_win and wrapping at NREQ. gnt[winner] is asserted combinationally in this cycle. On that edge: capture data[winner] into the shift register, set det = A, cnt = 0, bit index = 0, last_win = winner, then go to SHIFT. If no req is high, stay in IDLE and keep gnt = 0.
  - SHIFT: each cycle, feed in = shreg[WIDTH-1] to the detector, then shift shreg left.
  - Detector transitions:
    - A: in ? B : A
    - B: in ? B : C
    - C: in ? D : A
    - D: in ? B : C
  - cnt increments on every cycle whose detector next state is D. Overlaps count: 10101 gives 2.
  - After the WIDTH-th bit, go to REPORT.
  - REPORT: assert done for one cycle. Load done_id, match_cnt and match_any, all of which are registered. Then go to IDLE.
- req is ignored outside IDLE. A req that drops before its grant is simply not served.
- data is sampled only on the grant edge. Later changes to data do not affect the word in flight.
- Detector state does not carry across words; every word starts in A.
- cnt cannot overflow, because at most ceil(WIDTH/2) detections fit in a word.

## Timing
- Reset (async assert, sync-to-clk release): state = IDLE, det = A, cnt = 0, last_win = NREQ-1 (so req[0] has first priority).
- Reset values of outputs: gnt = 0, busy = 0, done = 0, done_id = 0, match_cnt = 0, match_any = 0.
- Per-word timing:
  - Grant is in cycle T0.
  - busy is high T0+1 .. T0+WIDTH+1.
  - done is high in cycle T0+WIDTH+1.
  - Earliest next gnt is T0+WIDTH+2, for a period of WIDTH+2 cycles per word.
- Reset mid-operation: the word is dropped, no done is generated, outputs clear, and the priority pointer returns to req[0].
- Simultaneous requests: exactly one grant per IDLE cycle. Under continuous requests from all NREQ requesters, no requester waits more than NREQ words.

## Test plan
1. Reset with all req high → all outputs 0. After release, the first gnt is 4'b0001 in the first IDLE cycle.
2. req[0] with data 8'b10100000 → done 9 cycles after gnt, done_id = 0, match_cnt = 1, match_any = 1.
3. Overlap and boundary cases on req[2]:
   - 8'b10101010 → match_cnt = 3.
   - 8'b11011011 → 2.
   - 8'b00000101 (match on the final bit) → 1.
   - 8'b11111111 → 0, match_any = 0.
4. req = 4'b1111 held, data 8'hA0/8'hAA/8'hDB/8'h05 → gnt order 0,1,2,3,0 at 10-cycle spacing; results 1/3/2/1 with matching done_id.
5. req[1] granted, then areset_n pulsed low during SHIFT bit 4 → no done. After release, with req = 4'b0011, gnt goes to req[0] first.
6. Change data[0] on every cycle after its grant → the result reflects only the word captured on the grant edge. outputs stay stable between done strobes.

Source files
------------

// File: rtl/seq101_share_arb.sv
// Round-robin arbiter sharing one serial "101" Moore detector among NREQ requesters.
// The granted word is shifted MSB-first and overlapping detections are counted and reported per requester.
module seq101_share_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = $clog2(NREQ),
  parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CNTW-1:0]       match_cnt,
  output logic                  match_any
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
  typedef enum logic [1:0] {DET_A, DET_B, DET_C, DET_D} det_t;

  state_t           state, state_nxt;
  det_t             det, det_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] words [NREQ];
  logic [CNTW-1:0]  cnt, cnt_nxt, bit_idx;
  logic [IDW-1:0]   last_win, winner, cand;
  logic             win_found, last_bit, det_in;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign words[g] = data[g*WIDTH +: WIDTH];
  end

  // Scan starting just after the previous winner, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_win) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  // Grant is gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    gnt = '0;
    if (areset_n && state == IDLE && win_found) gnt[winner] = 1'b1;
  end

  assign det_in   = shreg[WIDTH-1];
  assign last_bit = (bit_idx == CNTW'(WIDTH - 1));

  always_comb begin
    det_nxt = det;
    case (det)
      DET_A:   det_nxt = det_in ? DET_B : DET_A;
      DET_B:   det_nxt = det_in ? DET_B : DET_C;
      DET_C:   det_nxt = det_in ? DET_D : DET_A;
      DET_D:   det_nxt = det_in ? DET_B : DET_C;
      default: det_nxt = DET_A;
    endcase
    cnt_nxt = cnt + CNTW'(det_nxt == DET_D);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Results are loaded on the edge entering REPORT so they are valid alongside done.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      shreg     <= '0;
      det       <= DET_A;
      cnt       <= '0;
      bit_idx   <= '0;
      last_win  <= IDW'(NREQ - 1);
      done_id   <= '0;
      match_cnt <= '0;
      match_any <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            shreg    <= words[winner];
            det      <= DET_A;
            cnt      <= '0;
            bit_idx  <= '0;
            last_win <= winner;
          end
        end
        SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          det     <= det_nxt;
          cnt     <= cnt_nxt;
          bit_idx <= bit_idx + CNTW'(1);
          if (last_bit) begin
            done_id   <= last_win;
            match_cnt <= cnt_nxt;
            match_any <= (cnt_nxt != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == REPORT);

endmodule
